// File: rtl/id_operand_fetch_if.sv
// ID-to-ID/EX handshake bundle: instruction fields entering decode and the
// resolved operands leaving the ID/EX pipeline register.
interface id_operand_fetch_if #(
  parameter int XLEN = 32
) ();

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [4:0]      in_rs1;
  logic [4:0]      in_rs2;
  logic            in_use1;
  logic            in_use2;
  logic [4:0]      in_rd;
  logic            in_rd_we;
  logic            in_is_load;
  logic [XLEN-1:0] in_imm;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_op1;
  logic [XLEN-1:0] out_op2;
  logic [XLEN-1:0] out_imm;
  logic [4:0]      out_rd;
  logic            out_rd_we;
  logic            out_is_load;

  // master is the pipeline around the block; slave is the operand-fetch stage
  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_use1, in_use2,
           in_rd, in_rd_we, in_is_load, in_imm, out_ready,
    input  in_ready, out_valid, out_pc, out_op1, out_op2, out_imm,
           out_rd, out_rd_we, out_is_load
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_use1, in_use2,
           in_rd, in_rd_we, in_is_load, in_imm, out_ready,
    output in_ready, out_valid, out_pc, out_op1, out_op2, out_imm,
           out_rd, out_rd_we, out_is_load
  );

endinterface

// File: rtl/id_operand_fetch.sv
// Decode-stage operand reader: register-file read, EX/MEM/WB bypass,
// load-use bubble insertion and the ID/EX pipeline register.
module id_operand_fetch #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  id_operand_fetch_if.slave bus,
  output logic [4:0]       rf_rR1,
  output logic [4:0]       rf_rR2,
  input  logic [XLEN-1:0]  rf_rD1,
  input  logic [XLEN-1:0]  rf_rD2,
  input  logic             ex_we,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_wR,
  input  logic [XLEN-1:0]  ex_value,
  input  logic             mem_we,
  input  logic [4:0]       mem_wR,
  input  logic [XLEN-1:0]  mem_value,
  input  logic             wb_we,
  input  logic [4:0]       wb_wR,
  input  logic [XLEN-1:0]  wb_value,
  input  logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rd_q;
  logic            rd_we_q;
  logic            is_load_q;

  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            ex_fwd_ok;
  logic            load_use;
  logic            adv;

  assign rf_rR1 = bus.in_rs1;
  assign rf_rR2 = bus.in_rs2;

  // A load in EX has no data yet, so it never bypasses; it stalls instead.
  assign ex_fwd_ok = ex_we && !ex_is_load;

  always_comb begin
    op1 = rf_rD1;
    if (bus.in_rs1 != 5'd0) begin
      if (ex_fwd_ok && ex_wR == bus.in_rs1)
        op1 = ex_value;
      else if (mem_we && mem_wR == bus.in_rs1)
        op1 = mem_value;
      else if (wb_we && wb_wR == bus.in_rs1)
        op1 = wb_value;
    end
  end

  always_comb begin
    op2 = rf_rD2;
    if (bus.in_rs2 != 5'd0) begin
      if (ex_fwd_ok && ex_wR == bus.in_rs2)
        op2 = ex_value;
      else if (mem_we && mem_wR == bus.in_rs2)
        op2 = mem_value;
      else if (wb_we && wb_wR == bus.in_rs2)
        op2 = wb_value;
    end
  end

  assign load_use = bus.in_valid && ex_we && ex_is_load && (ex_wR != 5'd0) &&
                    ((bus.in_use1 && ex_wR == bus.in_rs1) ||
                     (bus.in_use2 && ex_wR == bus.in_rs2));

  assign adv          = !valid_q || bus.out_ready;
  assign bus.in_ready = adv && !load_use && !flush;

  // Data fields are cleared only by reset; a bubble or flush just drops valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      imm_q     <= '0;
      rd_q      <= '0;
      rd_we_q   <= 1'b0;
      is_load_q <= 1'b0;
      stall_cnt <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (adv) begin
      if (load_use) begin
        valid_q <= 1'b0;
        if (stall_cnt != {CNT_W{1'b1}})
          stall_cnt <= stall_cnt + CNT_W'(1);
      end else if (bus.in_valid) begin
        valid_q   <= 1'b1;
        pc_q      <= bus.in_pc;
        op1_q     <= op1;
        op2_q     <= op2;
        imm_q     <= bus.in_imm;
        rd_q      <= bus.in_rd;
        rd_we_q   <= bus.in_rd_we;
        is_load_q <= bus.in_is_load;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_op1     = op1_q;
  assign bus.out_op2     = op2_q;
  assign bus.out_imm     = imm_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rd_we   = rd_we_q;
  assign bus.out_is_load = is_load_q;

endmodule

// File: tb/tb_id_operand_fetch.sv
// Directed bench for id_operand_fetch: stimulus pushes expected ID/EX contents
// into a queue, an independent monitor pops them on each output handshake.
module tb_id_operand_fetch;

  localparam int XLEN  = 32;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       rf_rR1, rf_rR2;
  logic [XLEN-1:0]  rf_rD1, rf_rD2;
  logic             ex_we, ex_is_load;
  logic [4:0]       ex_wR;
  logic [XLEN-1:0]  ex_value;
  logic             mem_we;
  logic [4:0]       mem_wR;
  logic [XLEN-1:0]  mem_value;
  logic             wb_we;
  logic [4:0]       wb_wR;
  logic [XLEN-1:0]  wb_value;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  id_operand_fetch_if #(.XLEN(XLEN)) bus ();

  id_operand_fetch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .rf_rR1(rf_rR1), .rf_rR2(rf_rR2), .rf_rD1(rf_rD1), .rf_rD2(rf_rD2),
    .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_wR(ex_wR), .ex_value(ex_value),
    .mem_we(mem_we), .mem_wR(mem_wR), .mem_value(mem_value),
    .wb_we(wb_we), .wb_wR(wb_wR), .wb_value(wb_value),
    .flush(flush), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use1;
    logic        use2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_load;
    logic [31:0] imm;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        ex_we;
    logic        ex_ld;
    logic [4:0]  ex_wr;
    logic [31:0] ex_val;
    logic        mem_we;
    logic [4:0]  mem_wr;
    logic [31:0] mem_val;
    logic        wb_we;
    logic [4:0]  wb_wr;
    logic [31:0] wb_val;
    logic        flush;
    logic        out_ready;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_load;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;
  vec_t v;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t s);
    bus.in_valid   = s.valid;
    bus.in_pc      = s.pc;
    bus.in_rs1     = s.rs1;
    bus.in_rs2     = s.rs2;
    bus.in_use1    = s.use1;
    bus.in_use2    = s.use2;
    bus.in_rd      = s.rd;
    bus.in_rd_we   = s.rd_we;
    bus.in_is_load = s.is_load;
    bus.in_imm     = s.imm;
    bus.out_ready  = s.out_ready;
    rf_rD1         = s.rd1;
    rf_rD2         = s.rd2;
    ex_we          = s.ex_we;
    ex_is_load     = s.ex_ld;
    ex_wR          = s.ex_wr;
    ex_value       = s.ex_val;
    mem_we         = s.mem_we;
    mem_wR         = s.mem_wr;
    mem_value      = s.mem_val;
    wb_we          = s.wb_we;
    wb_wR          = s.wb_wr;
    wb_value       = s.wb_val;
    flush          = s.flush;
  endtask

  task automatic step(input vec_t s);
    @(posedge clk);
    #1;
    applyStimulus(s);
    @(negedge clk);
  endtask

  task automatic pushExp(input logic [31:0] pc, input logic [31:0] op1, input logic [31:0] op2,
                         input logic [31:0] imm, input logic [4:0] rd, input logic rd_we,
                         input logic is_load);
    exp_t e;
    e.pc = pc; e.op1 = op1; e.op2 = op2; e.imm = imm;
    e.rd = rd; e.rd_we = rd_we; e.is_load = is_load;
    expQ.push_back(e);
  endtask

  function automatic vec_t idleVec();
    vec_t r;
    r = '0;
    r.out_ready = 1'b1;
    return r;
  endfunction

  // Monitor: every accepted ID/EX output must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && bus.out_valid && bus.out_ready && !flush) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_out: got pc 0x%0h, expected no output at %0t", bus.out_pc, $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("out_pc",      bus.out_pc,            e.pc);
        checkOutput("out_op1",     bus.out_op1,           e.op1);
        checkOutput("out_op2",     bus.out_op2,           e.op2);
        checkOutput("out_imm",     bus.out_imm,           e.imm);
        checkOutput("out_rd",      32'(bus.out_rd),       32'(e.rd));
        checkOutput("out_rd_we",   32'(bus.out_rd_we),    32'(e.rd_we));
        checkOutput("out_is_load", 32'(bus.out_is_load),  32'(e.is_load));
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    applyStimulus(idleVec());
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("reset_out_op1", bus.out_op1, 32'd0);

    // EX bypass beats MEM for the same register
    v = idleVec();
    v.valid = 1; v.pc = 32'h100; v.rs1 = 5; v.use1 = 1; v.rs2 = 6; v.use2 = 1;
    v.rd1 = 32'hAAAA; v.rd2 = 32'h66; v.rd = 1; v.rd_we = 1; v.imm = 32'h4;
    v.ex_we = 1; v.ex_wr = 5; v.ex_val = 32'h11;
    v.mem_we = 1; v.mem_wr = 5; v.mem_val = 32'h22;
    pushExp(32'h100, 32'h11, 32'h66, 32'h4, 5'd1, 1'b1, 1'b0);
    step(v);
    checkOutput("ex_fwd_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rf_rR1", 32'(rf_rR1), 32'd5);
    checkOutput("rf_rR2", 32'(rf_rR2), 32'd6);

    // WB bypass over stale RF; x0 never bypasses from EX or MEM
    v = idleVec();
    v.valid = 1; v.pc = 32'h104; v.rs1 = 0; v.use1 = 1; v.rs2 = 3; v.use2 = 1;
    v.rd = 2; v.rd_we = 1; v.imm = 32'hFFFF_FFF0;
    v.ex_we = 1; v.ex_wr = 0; v.ex_val = 32'h77;
    v.mem_we = 1; v.mem_wr = 0; v.mem_val = 32'hFF;
    v.wb_we = 1; v.wb_wr = 3; v.wb_val = 32'hDEAD;
    pushExp(32'h104, 32'h0, 32'hDEAD, 32'hFFFF_FFF0, 5'd2, 1'b1, 1'b0);
    step(v);
    checkOutput("wb_in_ready", 32'(bus.in_ready), 32'd1);

    // Load-use on rs1: one bubble, then the load value arrives from MEM
    v = idleVec();
    v.valid = 1; v.pc = 32'h108; v.rs1 = 7; v.use1 = 1; v.rd1 = 32'h5;
    v.rd = 8; v.rd_we = 1; v.imm = 32'h8;
    v.ex_we = 1; v.ex_ld = 1; v.ex_wr = 7; v.ex_val = 32'hBAD;
    step(v);
    checkOutput("load_use_in_ready", 32'(bus.in_ready), 32'd0);
    v.ex_we = 0; v.ex_ld = 0; v.ex_wr = 0;
    v.mem_we = 1; v.mem_wr = 7; v.mem_val = 32'h1234;
    pushExp(32'h108, 32'h1234, 32'h0, 32'h8, 5'd8, 1'b1, 1'b0);
    step(v);
    checkOutput("bubble_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("bubble_stall_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("after_bubble_in_ready", 32'(bus.in_ready), 32'd1);

    // EX load to a register the instruction does not read: no stall, no EX bypass
    v = idleVec();
    v.valid = 1; v.pc = 32'h10C; v.rs1 = 7; v.use1 = 0; v.rs2 = 7; v.use2 = 0;
    v.rd1 = 32'h55; v.rd2 = 32'h77; v.rd = 9; v.rd_we = 0; v.is_load = 1;
    v.ex_we = 1; v.ex_ld = 1; v.ex_wr = 7; v.ex_val = 32'hBAD;
    pushExp(32'h10C, 32'h55, 32'h77, 32'h0, 5'd9, 1'b0, 1'b1);
    step(v);
    checkOutput("unused_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("unused_stall_cnt", 32'(stall_cnt), 32'd1);
    checkOutput("unused_prev_valid", 32'(bus.out_valid), 32'd1);

    // Instruction that will sit under backpressure and then be flushed
    v = idleVec();
    v.valid = 1; v.pc = 32'h110; v.rs1 = 9; v.use1 = 1; v.rd1 = 32'h99;
    v.rs2 = 10; v.use2 = 1; v.rd2 = 32'hA0; v.rd = 3; v.rd_we = 1; v.imm = 32'h10;
    pushExp(32'h110, 32'h99, 32'hA0, 32'h10, 5'd3, 1'b1, 1'b0);
    step(v);
    checkOutput("pre_bp_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 3; i++) begin
      v = idleVec();
      v.out_ready = 0;
      v.valid = 1; v.pc = 32'h114; v.rs1 = 9; v.use1 = 1; v.rd1 = 32'h1;
      if (i == 1) begin
        v.ex_we = 1; v.ex_ld = 1; v.ex_wr = 9;
      end
      step(v);
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_out_pc", bus.out_pc, 32'h110);
      checkOutput("bp_out_op1", bus.out_op1, 32'h99);
      checkOutput("bp_out_op2", bus.out_op2, 32'hA0);
      checkOutput("bp_stall_cnt", 32'(stall_cnt), 32'd1);
    end

    // Flush while stalled downstream and with a load-use hazard present
    v.flush = 1; v.ex_we = 1; v.ex_ld = 1; v.ex_wr = 9;
    void'(expQ.pop_front());
    step(v);
    checkOutput("flush_in_ready", 32'(bus.in_ready), 32'd0);
    step(idleVec());
    checkOutput("flush_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("flush_stall_cnt", 32'(stall_cnt), 32'd1);

    // Back-to-back: MEM beats WB on op1, EX on op2; then EX ALU result on op1
    v = idleVec();
    v.valid = 1; v.pc = 32'h200; v.rs1 = 4; v.use1 = 1; v.rs2 = 5; v.use2 = 1;
    v.rd1 = 32'h40; v.rd2 = 32'h50; v.rd = 10; v.rd_we = 1;
    v.ex_we = 1; v.ex_wr = 5; v.ex_val = 32'h500;
    v.mem_we = 1; v.mem_wr = 4; v.mem_val = 32'h4444;
    v.wb_we = 1; v.wb_wr = 4; v.wb_val = 32'h444;
    pushExp(32'h200, 32'h4444, 32'h500, 32'h0, 5'd10, 1'b1, 1'b0);
    step(v);
    checkOutput("b2b_a_in_ready", 32'(bus.in_ready), 32'd1);
    v = idleVec();
    v.valid = 1; v.pc = 32'h204; v.rs1 = 4; v.use1 = 1; v.rs2 = 5; v.use2 = 1;
    v.rd1 = 32'h1; v.rd2 = 32'h2; v.rd = 11; v.rd_we = 1;
    v.ex_we = 1; v.ex_wr = 4; v.ex_val = 32'hE4;
    v.wb_we = 1; v.wb_wr = 5; v.wb_val = 32'h5B;
    pushExp(32'h204, 32'hE4, 32'h5B, 32'h0, 5'd11, 1'b1, 1'b0);
    step(v);
    checkOutput("b2b_b_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("b2b_out_valid", 32'(bus.out_valid), 32'd1);
    step(idleVec());
    step(idleVec());

    // Asynchronous reset mid-cycle with a valid entry held in ID/EX
    v = idleVec();
    v.valid = 1; v.pc = 32'h300; v.rs1 = 1; v.use1 = 1; v.rd1 = 32'h31; v.rd = 1; v.rd_we = 1;
    pushExp(32'h300, 32'h31, 32'h0, 32'h0, 5'd1, 1'b1, 1'b0);
    step(v);
    v = idleVec();
    v.out_ready = 0;
    step(v);
    checkOutput("pre_reset_out_valid", 32'(bus.out_valid), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    void'(expQ.pop_front());
    #1;
    checkOutput("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_reset_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("async_reset_out_pc", bus.out_pc, 32'h0);
    checkOutput("async_reset_out_op1", bus.out_op1, 32'h0);
    #1 rst_n = 1'b1;

    // First edge after release acts as empty ID/EX, even with out_ready low
    v = idleVec();
    v.out_ready = 0;
    v.valid = 1; v.pc = 32'h304; v.rs1 = 0; v.use1 = 1; v.rd1 = 32'h0;
    v.rs2 = 2; v.use2 = 1; v.rd2 = 32'h22; v.rd = 4; v.rd_we = 1; v.imm = 32'hC;
    pushExp(32'h304, 32'h0, 32'h22, 32'hC, 5'd4, 1'b1, 1'b0);
    step(v);
    checkOutput("post_reset_in_ready", 32'(bus.in_ready), 32'd1);
    step(idleVec());
    step(idleVec());
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
